// File: rtl/perip_timer_cmp_if.sv
// Peripheral bus bundle for perip_timer_cmp: one access per cycle while ena is high,
// read data registered by the slave.
interface perip_timer_cmp_if;
  logic        ena;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output ena, rw, addr, wdata, input rdata);
  modport slave  (input ena, rw, addr, wdata, output rdata);
endinterface

// File: rtl/perip_timer_cmp.sv
// Prescaled free-running time counter with load/clear, coherent hi/lo reads, sticky
// overflow and NUM_CMP mtimecmp-style compare channels driving level interrupts.
module perip_timer_cmp_ch #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  input  logic [CNT_W-1:0] cnt,
  input  logic             ie,
  output logic [63:0]      cmp,
  output logic             match,
  output logic             irq
);
  // Compare value is stored at full 64 bits but only CNT_W bits take part in the match.
  assign match = cnt >= cmp[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp <= '1;
      irq <= 1'b0;
    end else begin
      if (wr_lo) cmp[31:0]  <= wdata;
      if (wr_hi) cmp[63:32] <= wdata;
      irq <= match & ie;
    end
  end
endmodule

module perip_timer_cmp #(
  parameter int TICK_DIV = 50,
  parameter int CNT_W    = 64,
  parameter int NUM_CMP  = 2
) (
  input  logic               clk,
  input  logic               rst,
  perip_timer_cmp_if.slave   bus,
  output logic [NUM_CMP-1:0] irq
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = CNT_W - 32;

  logic [4:0]                  a;
  logic                        wr, rd;
  logic [PW-1:0]               presc;
  logic [CNT_W-1:0]            cnt;
  logic [63:0]                 cnt64;
  logic                        en, ovf;
  logic [NUM_CMP-1:0]          ie, match;
  logic [NUM_CMP-1:0][63:0]    cmp;
  logic [31:0]                 shadow_hi, rdata, rd_mux;
  logic                        tick, clr, wr_ctrl, wr_lo, wr_hi, ovf_clr, wrap;
  logic                        unused_addr;

  assign a           = bus.addr[4:0];
  assign unused_addr = ^bus.addr[31:5];
  assign wr          = bus.ena & bus.rw;
  assign rd          = bus.ena & ~bus.rw;
  assign cnt64       = 64'(cnt);
  assign bus.rdata   = rdata;

  assign tick    = en && (presc == PW'(TICK_DIV - 1));
  assign wr_ctrl = wr && (a == 5'd2);
  assign clr     = wr_ctrl && bus.wdata[1];
  assign wr_lo   = wr && (a == 5'd0);
  assign wr_hi   = wr && (a == 5'd1);
  assign ovf_clr = wr && (a == 5'd3) && bus.wdata[16];
  // A software load or clear swallows the tick, so it cannot wrap either.
  assign wrap    = tick && !clr && !wr_lo && !wr_hi && (&cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      cnt   <= '0;
      en    <= 1'b1;
      ie    <= '0;
      ovf   <= 1'b0;
    end else begin
      if (clr)     presc <= '0;
      else if (en) presc <= tick ? '0 : presc + 1'b1;

      if (clr) cnt <= '0;
      else if (wr_lo || wr_hi) begin
        if (wr_lo) cnt[31:0]      <= bus.wdata;
        if (wr_hi) cnt[CNT_W-1:32] <= bus.wdata[HW-1:0];
      end else if (tick) cnt <= cnt + 1'b1;

      if (wr_ctrl) begin
        en <= bus.wdata[0];
        ie <= bus.wdata[8 +: NUM_CMP];
      end

      ovf <= (ovf & ~ovf_clr) | wrap;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (a)
      5'd0: rd_mux = cnt64[31:0];
      5'd1: rd_mux = shadow_hi;
      5'd2: begin
        rd_mux[0]            = en;
        rd_mux[8 +: NUM_CMP] = ie;
      end
      5'd3: begin
        rd_mux[NUM_CMP-1:0] = match;
        rd_mux[16]          = ovf;
      end
      default: ;
    endcase
    for (int i = 0; i < NUM_CMP; i++) begin
      if (a == 5'(4 + 2*i)) rd_mux = cmp[i][31:0];
      if (a == 5'(5 + 2*i)) rd_mux = cmp[i][63:32];
    end
  end

  // The LO read snapshots the upper half so a following HI read is carry-coherent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata     <= '0;
      shadow_hi <= '0;
    end else if (rd) begin
      rdata <= rd_mux;
      if (a == 5'd0) shadow_hi <= cnt64[63:32];
    end
  end

  for (genvar i = 0; i < NUM_CMP; i++) begin : g_ch
    perip_timer_cmp_ch #(.CNT_W(CNT_W)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .wr_lo (wr && (a == 5'(4 + 2*i))),
      .wr_hi (wr && (a == 5'(5 + 2*i))),
      .wdata (bus.wdata),
      .cnt   (cnt),
      .ie    (ie[i]),
      .cmp   (cmp[i]),
      .match (match[i]),
      .irq   (irq[i])
    );
  end
endmodule

// File: tb/tb_perip_timer_cmp.sv
// Directed-vector bench for perip_timer_cmp; each bus op occupies exactly one clock edge,
// so expected values follow from counting edges since the last clear.
module tb_perip_timer_cmp;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] irq;
  logic [31:0] d;
  int n_vec = 0;
  int n_err = 0;

  perip_timer_cmp_if bus ();

  perip_timer_cmp #(.TICK_DIV(50), .CNT_W(64), .NUM_CMP(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .irq (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the access happens on the next posedge, returns at the negedge after.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] v);
    bus.ena = 1'b1; bus.rw = 1'b1; bus.addr = a; bus.wdata = v;
    @(negedge clk);
    bus.ena = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
    bus.ena = 1'b1; bus.rw = 1'b0; bus.addr = a;
    @(negedge clk);
    bus.ena = 1'b0;
    v = bus.rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.ena = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    idle(3);
    rst = 1'b1;

    // free run: 500 edges at /50 -> time 10
    idle(500);
    bus_rd(0, d); chk("run_lo", d, 32'd10);
    bus_rd(1, d); chk("run_hi", d, 32'd0);
    chk("run_irq", 32'(irq), 32'h0);
    bus_rd(4, d); chk("rst_cmp0_lo", d, 32'hFFFF_FFFF);
    bus_rd(2, d); chk("rst_ctrl", d, 32'h1);
    bus_rd(3, d); chk("rst_stat", d, 32'h0);

    // coherent hi/lo across carry into bit 32
    bus_wr(2, 32'h3);
    bus_wr(0, 32'hFFFF_FFFF);
    bus_wr(1, 32'h0);
    idle(47);
    bus_rd(0, d); chk("coh_lo_pre", d, 32'hFFFF_FFFF);
    bus_rd(1, d); chk("coh_hi_latched", d, 32'h0);
    bus_rd(0, d); chk("coh_lo_post", d, 32'h0);
    idle(100);
    bus_rd(1, d); chk("coh_hi_hold", d, 32'h1);
    bus_rd(0, d); chk("coh_lo_later", d, 32'h2);

    // compare channel 0 / irq timing
    bus_wr(2, 32'h103);
    bus_wr(4, 32'd100);
    bus_wr(5, 32'd0);
    bus_wr(0, 32'd98);
    idle(97);
    chk("irq_at_100", 32'(irq), 32'h0);
    idle(1);
    chk("irq_rise", 32'(irq), 32'h1);
    bus_rd(3, d); chk("stat_match", d, 32'h1);
    bus_wr(5, 32'd1);
    chk("irq_lag", 32'(irq), 32'h1);
    idle(1);
    chk("irq_fall", 32'(irq), 32'h0);
    bus_rd(3, d); chk("stat_nomatch", d, 32'h0);

    // overflow: wrap sets, write clears, wrap beats same-cycle clear
    bus_wr(2, 32'h3);
    bus_wr(0, 32'hFFFF_FFFF);
    bus_wr(1, 32'hFFFF_FFFF);
    idle(48);
    bus_rd(3, d); chk("ovf_set", d, 32'h0001_0000);
    bus_wr(3, 32'h0001_0000);
    bus_rd(3, d); chk("ovf_clr", d, 32'h0);
    bus_wr(0, 32'hFFFF_FFFF);
    bus_wr(1, 32'hFFFF_FFFF);
    idle(44);
    bus_wr(3, 32'h0001_0000);
    bus_rd(3, d); chk("ovf_set_wins", d, 32'h0001_0000);
    bus_rd(0, d); chk("wrap_lo", d, 32'h0);

    // enable freeze
    bus_wr(2, 32'h3);
    bus_wr(0, 32'd5);
    bus_wr(2, 32'h0);
    idle(200);
    bus_rd(0, d); chk("frozen_lo", d, 32'd5);
    bus_rd(2, d); chk("ctrl_off", d, 32'h0);

    // load in the tick cycle wins; prescaler keeps its phase
    bus_wr(2, 32'h3);
    bus_wr(0, 32'd7);
    idle(48);
    bus_wr(0, 32'h1234);
    idle(1);
    bus_rd(0, d); chk("load_vs_tick", d, 32'h1234);
    idle(47);
    bus_rd(0, d); chk("phase_pre", d, 32'h1234);
    bus_rd(0, d); chk("phase_tick", d, 32'h1235);

    // clr restarts a full prescaler period
    bus_wr(2, 32'h3);
    idle(49);
    bus_rd(0, d); chk("clr_pre", d, 32'h0);
    bus_rd(0, d); chk("clr_tick", d, 32'h1);
    bus_rd(2, d); chk("ctrl_clr_rd0", d, 32'h1);

    // async reset mid-read with an irq pending
    bus_wr(2, 32'h103);
    bus_wr(4, 32'd0);
    bus_wr(5, 32'd0);
    idle(2);
    chk("pend_irq", 32'(irq), 32'h1);
    bus_rd(6, d); chk("cmp1_lo", d, 32'hFFFF_FFFF);
    bus.ena = 1'b1; bus.rw = 1'b0; bus.addr = 32'd6;
    #2 rst = 1'b0;
    #1;
    chk("async_rdata", bus.rdata, 32'h0);
    chk("async_irq", 32'(irq), 32'h0);
    @(negedge clk);
    bus.ena = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus_rd(0, d); chk("post_rst_lo", d, 32'h0);
    bus_rd(4, d); chk("post_rst_cmp0", d, 32'hFFFF_FFFF);
    bus_rd(2, d); chk("post_rst_ctrl", d, 32'h1);
    bus_rd(1, d); chk("post_rst_hi", d, 32'h0);
    bus_rd(3, d); chk("post_rst_stat", d, 32'h0);
    chk("post_rst_irq", 32'(irq), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
